// File: rtl/ce_acc_tm_if.sv
// Beat/result bundle for the time-multiplexed convolution element.
// The master drives beats in and takes results; the slave is the element itself.
// Ports: data2conv/w/bias/en_in -> in_ready; d_out/en_out -> out_ready; fsm_state is status only.
interface ce_acc_tm_if #(
    parameter int LANES  = 4,
    parameter int KERNEL = 3,
    parameter int N      = 4,
    parameter int M      = 4,
    parameter int ACC_W  = 17,
    parameter int OUT_W  = 14
);
    logic [LANES*KERNEL*KERNEL*N-1:0] data2conv;
    logic [LANES*KERNEL*KERNEL*M-1:0] w;
    logic [ACC_W-1:0]                 bias;
    logic                             en_in;
    logic                             in_ready;
    logic                             out_ready;
    logic [OUT_W-1:0]                 d_out;
    logic                             en_out;
    logic [1:0]                       fsm_state;

    modport master (
        output data2conv, w, bias, en_in, out_ready,
        input  in_ready, d_out, en_out, fsm_state
    );

    modport slave (
        input  data2conv, w, bias, en_in, out_ready,
        output in_ready, d_out, en_out, fsm_state
    );
endinterface

// File: rtl/ce_acc_tm.sv
// Convolution element: LANES channel windows MAC'd per beat, CL_IN/LANES beats plus bias per pixel, round/shift/ReLU/saturate.
// Latency: result valid after the 2nd edge following acceptance of a pixel's last beat; one beat per cycle.
// Backpressure: while en_out is held without out_ready, in_ready is low and the whole pipe, counter and accumulator freeze.
// Ports: clk, rst (sync, active high), bus (slave): beats in via data2conv/w/bias/en_in/in_ready,
//        results out via d_out/en_out/out_ready, fsm_state reports IDLE/ACCUM/DRAIN/HOLD.
module ce_acc_tm #(
    parameter int CL_IN  = 8,
    parameter int LANES  = 4,
    parameter int KERNEL = 3,
    parameter int N      = 4,
    parameter int M      = 4,
    parameter int SR     = 2,
    parameter int RELU   = 1,
    parameter int OUT_W  = N + 10,
    parameter int ACC_W  = N + M + $clog2(KERNEL*KERNEL*CL_IN) + 2
) (
    input  logic        clk,
    input  logic        rst,
    ce_acc_tm_if.slave  bus
);
    localparam int KK     = KERNEL * KERNEL;
    localparam int PASSES = CL_IN / LANES;
    localparam int CW     = (PASSES > 1) ? $clog2(PASSES) : 1;
    // Post-processing width: wide enough for acc + psum + rounding without wrap.
    localparam int SW     = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 2;

    localparam logic signed [SW-1:0] RND  = SW'((1 << SR) >> 1);
    localparam logic signed [SW-1:0] MAXV = SW'((1 << (OUT_W-1)) - 1);
    localparam logic signed [SW-1:0] MINV = ~MAXV;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DRAIN = 2'd2,
        S_HOLD  = 2'd3
    } state_e;

    // Registered state
    logic [CW-1:0]           cnt_q,     cnt_d;
    logic                    p_vld_q,   p_vld_d;
    logic                    p_first_q, p_first_d;
    logic                    p_last_q,  p_last_d;
    logic signed [ACC_W-1:0] psum_q,    psum_d;
    logic signed [ACC_W-1:0] p_bias_q,  p_bias_d;
    logic signed [ACC_W-1:0] acc_q,     acc_d;
    logic [OUT_W-1:0]        d_out_q,   d_out_d;
    logic                    en_out_q,  en_out_d;
    state_e                  state_q,   state_d;

    // Combinational
    logic                    stall, in_ready, accept, cnt_last;
    logic [N-1:0]            dv;
    logic [M-1:0]            wv;
    logic [N+M-1:0]          prod;
    logic signed [ACC_W-1:0] psum;
    logic signed [SW-1:0]    sum_w, rnd, r, r2;

    // Stage 0: signed MAC over every lane's window. Operands are sign-extended to
    // the full product width so the unsigned multiply yields the exact signed product.
    always_comb begin
        psum = '0;
        dv   = '0;
        wv   = '0;
        prod = '0;
        for (int l = 0; l < LANES; l++) begin
            for (int k = 0; k < KK; k++) begin
                dv   = bus.data2conv[(l*KK + k)*N +: N];
                wv   = bus.w[(l*KK + k)*M +: M];
                prod = {{M{dv[N-1]}}, dv} * {{N{wv[M-1]}}, wv};
                psum = psum + {{(ACC_W-N-M){prod[N+M-1]}}, prod};
            end
        end
    end

    assign stall    = en_out_q && !bus.out_ready;
    assign in_ready = !rst && !stall;
    assign accept   = bus.en_in && in_ready;
    assign cnt_last = (cnt_q == CW'(PASSES - 1));

    // Stage 2 arithmetic and post-processing (round half-up, shift, ReLU, saturate).
    always_comb begin
        sum_w = (p_first_q ? SW'(p_bias_q) : SW'(acc_q)) + SW'(psum_q);
        rnd   = sum_w + RND;
        r     = rnd >>> SR;
        r2    = r;
        if (RELU != 0 && r < 0) begin
            r2 = '0;
        end
    end

    always_comb begin
        cnt_d     = cnt_q;
        p_vld_d   = p_vld_q;
        p_first_d = p_first_q;
        p_last_d  = p_last_q;
        psum_d    = psum_q;
        p_bias_d  = p_bias_q;
        acc_d     = acc_q;
        d_out_d   = d_out_q;
        en_out_d  = en_out_q;

        if (!stall) begin
            // Stage 1: capture the beat with its position in the pixel; the bias
            // rides along so a following pixel's first beat cannot overwrite it.
            p_vld_d = accept;
            if (accept) begin
                psum_d    = psum;
                p_first_d = (cnt_q == '0);
                p_last_d  = cnt_last;
                p_bias_d  = bus.bias;
                cnt_d     = cnt_last ? '0 : cnt_q + 1'b1;
            end

            // Not stalled with en_out high means the result is consumed this edge.
            en_out_d = 1'b0;

            // Stage 2: accumulate; the last beat of a pixel produces the result.
            if (p_vld_q) begin
                acc_d = sum_w[ACC_W-1:0];
                if (p_last_q) begin
                    en_out_d = 1'b1;
                    if (r2 > MAXV) begin
                        d_out_d = MAXV[OUT_W-1:0];
                    end else if (r2 < MINV) begin
                        d_out_d = MINV[OUT_W-1:0];
                    end else begin
                        d_out_d = r2[OUT_W-1:0];
                    end
                end
            end
        end
    end

    // Status FSM, derived from the next-cycle pipe contents: a held result
    // dominates, then a last beat in flight, then any partial pixel.
    always_comb begin
        state_d = S_IDLE;
        if (en_out_d && !bus.out_ready) begin
            state_d = S_HOLD;
        end else if (p_vld_d && p_last_d) begin
            state_d = S_DRAIN;
        end else if (cnt_d != '0 || p_vld_d) begin
            state_d = S_ACCUM;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            p_vld_q   <= 1'b0;
            p_first_q <= 1'b0;
            p_last_q  <= 1'b0;
            psum_q    <= '0;
            p_bias_q  <= '0;
            acc_q     <= '0;
            d_out_q   <= '0;
            en_out_q  <= 1'b0;
            state_q   <= S_IDLE;
        end else begin
            cnt_q     <= cnt_d;
            p_vld_q   <= p_vld_d;
            p_first_q <= p_first_d;
            p_last_q  <= p_last_d;
            psum_q    <= psum_d;
            p_bias_q  <= p_bias_d;
            acc_q     <= acc_d;
            d_out_q   <= d_out_d;
            en_out_q  <= en_out_d;
            state_q   <= state_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.d_out     = d_out_q;
    assign bus.en_out    = en_out_q;
    assign bus.fsm_state = state_q;
endmodule
